// File: rtl/riscv_pkg.sv
// Shared core definitions: datapath widths and the writeback entry carried
// through the load-return queue.
package riscv_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Generic synchronous FIFO with occupancy count; pushes when full and pops
// when empty are ignored.
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 37
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/writeback_unit.sv
// Register-file write-port driver: ALU results take priority, queued load
// returns fill the gaps, and a pending-load scoreboard drives decode stall.
module writeback_unit #(
  parameter int LQ_DEPTH = 4,
  parameter int XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            stall,
  output logic [31:0]     busy,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] write_data,
  output logic            reg_write
);
  import riscv_pkg::*;

  localparam int CW = $clog2(LQ_DEPTH) + 1;

  logic            alu_sel, lq_push, lq_pop, lq_empty, lq_full_unused;
  logic [CW-1:0]   lq_count;
  wb_entry_t       ld_entry, lq_head;
  logic            wb_is_load;
  logic [31:0]     set_mask, clr_mask;

  // Ready is driven from the registered count only, so a full queue stays
  // closed even in a cycle where it also pops.
  assign ld_ready = !rst && (lq_count != CW'(LQ_DEPTH));
  assign ld_entry = '{rd: ld_rd, data: ld_data};
  assign lq_push  = ld_valid && ld_ready && (ld_rd != '0);
  assign alu_sel  = alu_valid && (alu_rd != '0);
  assign lq_pop   = !alu_sel && !lq_empty;

  wb_fifo #(
    .DEPTH(LQ_DEPTH),
    .WIDTH($bits(wb_entry_t))
  ) u_lq (
    .clk   (clk),
    .rst   (rst),
    .push  (lq_push),
    .din   (ld_entry),
    .pop   (lq_pop),
    .dout  (lq_head),
    .full  (lq_full_unused),
    .empty (lq_empty),
    .count (lq_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write  <= 1'b0;
      wb_is_load <= 1'b0;
      rd         <= '0;
      write_data <= '0;
    end else begin
      reg_write  <= alu_sel || lq_pop;
      wb_is_load <= lq_pop;
      if (alu_sel) begin
        rd         <= alu_rd;
        write_data <= alu_data;
      end else if (lq_pop) begin
        rd         <= lq_head.rd;
        write_data <= lq_head.data;
      end
    end
  end

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_valid && issue_rd != '0) set_mask[issue_rd] = 1'b1;
    if (reg_write && wb_is_load)       clr_mask[rd]       = 1'b1;
  end

  // Set is applied after clear so a reissue to a completing register wins.
  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= ((busy & ~clr_mask) | set_mask) & 32'hFFFF_FFFE;
  end

  assign stall = busy[rs1] | busy[rs2] | (issue_valid & busy[issue_rd]);
endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: queue-based reference model compared every cycle,
// a table of ALU vectors, directed load/scoreboard sequences, random traffic.
module tb_writeback_unit;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst, alu_valid, ld_valid, issue_valid;
  logic [4:0]  alu_rd, ld_rd, issue_rd, rs1, rs2;
  logic [31:0] alu_data, ld_data;
  logic        ld_ready, stall, reg_write;
  logic [31:0] busy, write_data;
  logic [4:0]  rd;

  always #5 clk = ~clk;

  writeback_unit #(.LQ_DEPTH(D), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2),
    .stall(stall), .busy(busy), .rd(rd), .write_data(write_data),
    .reg_write(reg_write)
  );

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  // Reference model: pending loads as a queue, scoreboard as a plain bitmap.
  typedef struct packed { logic [4:0] rd; logic [31:0] d; } ent_t;
  ent_t        q[$];
  logic [31:0] mbusy = '0;
  logic        m_rw = 1'b0, m_isld = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_wd = '0;

  task automatic model_step();
    logic [31:0] nb;
    logic        accept;
    ent_t        e;
    if (rst) begin
      q.delete();
      mbusy = '0; m_rw = 1'b0; m_isld = 1'b0; m_rd = '0; m_wd = '0;
    end else begin
      assert (!(issue_valid && issue_rd != 0 && mbusy[issue_rd] &&
                !(m_rw && m_isld && m_rd == issue_rd)))
        else $error("illegal issue to pending register %0d", issue_rd);
      nb = mbusy;
      if (m_rw && m_isld) nb[m_rd] = 1'b0;
      if (issue_valid && issue_rd != 0) nb[issue_rd] = 1'b1;
      accept = ld_valid && (q.size() != D);
      if (alu_valid && alu_rd != 0) begin
        m_rw = 1'b1; m_isld = 1'b0; m_rd = alu_rd; m_wd = alu_data;
      end else if (q.size() != 0) begin
        e = q.pop_front();
        m_rw = 1'b1; m_isld = 1'b1; m_rd = e.rd; m_wd = e.d;
      end else begin
        m_rw = 1'b0;
      end
      if (accept && ld_rd != 0) q.push_back('{ld_rd, ld_data});
      mbusy = nb;
    end
  endtask

  task automatic sample();
    logic exp_rdy, exp_stall;
    @(negedge clk);
    exp_rdy   = !rst && (q.size() != D);
    exp_stall = mbusy[rs1] | mbusy[rs2] | (issue_valid & mbusy[issue_rd]);
    chk("m_reg_write", {31'b0, reg_write}, {31'b0, m_rw});
    if (m_rw) begin
      chk("m_rd", {27'b0, rd}, {27'b0, m_rd});
      chk("m_write_data", write_data, m_wd);
    end
    chk("m_busy", busy, mbusy);
    chk("m_ld_ready", {31'b0, ld_ready}, {31'b0, exp_rdy});
    chk("m_stall", {31'b0, stall}, {31'b0, exp_stall});
  endtask

  task automatic adv();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    ld_valid = 0; ld_rd = '0; ld_data = '0;
    issue_valid = 0; issue_rd = '0; rs1 = '0; rs2 = '0;
  endtask

  typedef struct {
    logic       av; logic [4:0] ard; logic [31:0] ad;
    logic       erw; logic [4:0] erd; logic [31:0] ewd;
  } vec_t;
  vec_t vt[6];

  int          wr_rds[$];
  int          wr_cyc[$];
  logic [7:0]  exp_rdy4;
  logic        acc;
  int          k;
  logic [4:0]  r;

  initial begin
    vt[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd5,  32'hDEADBEEF};
    vt[1] = '{1'b1, 5'd0,  32'h11111111, 1'b0, 5'd5,  32'hDEADBEEF};
    vt[2] = '{1'b0, 5'd6,  32'h22222222, 1'b0, 5'd5,  32'hDEADBEEF};
    vt[3] = '{1'b1, 5'd31, 32'hA5A5A5A5, 1'b1, 5'd31, 32'hA5A5A5A5};
    vt[4] = '{1'b1, 5'd1,  32'h00000001, 1'b1, 5'd1,  32'h00000001};
    vt[5] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd1,  32'h00000001};

    // Reset held two cycles with a load offered.
    idle();
    rst = 1; ld_valid = 1; ld_rd = 5'd4; ld_data = 32'h4444;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      sample();
      chk("rst_ld_ready", {31'b0, ld_ready}, 32'd0);
      chk("rst_reg_write", {31'b0, reg_write}, 32'd0);
      chk("rst_busy", busy, 32'd0);
      adv();
    end
    rst = 0; ld_rd = 5'd0;
    sample();
    chk("rel_ld_ready", {31'b0, ld_ready}, 32'd1);
    adv();
    idle();

    // ALU table.
    for (int i = 0; i < 6; i++) begin
      alu_valid = vt[i].av; alu_rd = vt[i].ard; alu_data = vt[i].ad;
      sample();
      if (i > 0) begin
        chk("tbl_reg_write", {31'b0, reg_write}, {31'b0, vt[i-1].erw});
        chk("tbl_rd", {27'b0, rd}, {27'b0, vt[i-1].erd});
        chk("tbl_write_data", write_data, vt[i-1].ewd);
      end
      adv();
    end
    idle();
    sample();
    chk("tbl_reg_write", {31'b0, reg_write}, {31'b0, vt[5].erw});
    chk("tbl_rd", {27'b0, rd}, {27'b0, vt[5].erd});
    chk("tbl_write_data", write_data, vt[5].ewd);
    adv();

    // Load to x7 with decode waiting on rs1=7.
    rs1 = 5'd7; issue_valid = 1; issue_rd = 5'd7;
    sample(); chk("t3_stall_t0", {31'b0, stall}, 32'd0); adv();
    issue_valid = 0; issue_rd = '0;
    for (int i = 1; i <= 4; i++) begin
      sample(); chk("t3_stall_wait", {31'b0, stall}, 32'd1); adv();
    end
    ld_valid = 1; ld_rd = 5'd7; ld_data = 32'h1234;
    sample(); chk("t3_ld_ready", {31'b0, ld_ready}, 32'd1); adv();
    ld_valid = 0; ld_rd = '0; ld_data = '0;
    sample(); chk("t3_no_write_t6", {31'b0, reg_write}, 32'd0); adv();
    sample();
    chk("t3_write_t7", {31'b0, reg_write}, 32'd1);
    chk("t3_rd_t7", {27'b0, rd}, 32'd7);
    chk("t3_data_t7", write_data, 32'h1234);
    chk("t3_stall_t7", {31'b0, stall}, 32'd1);
    adv();
    sample();
    chk("t3_busy7_t8", {31'b0, busy[7]}, 32'd0);
    chk("t3_stall_t8", {31'b0, stall}, 32'd0);
    adv();
    idle();

    // ALU hogs the port while five loads are offered.
    exp_rdy4 = 8'b1000_1111;  // bit c = expected ld_ready in cycle c
    k = 0;
    for (int c = 0; c < 24 && wr_rds.size() < 5; c++) begin
      alu_valid = (c < 6); alu_rd = 5'd3; alu_data = 32'(c);
      ld_valid = (k < 5); ld_rd = 5'(8 + k); ld_data = 32'h100 + 32'(k);
      sample();
      if (c < 8) chk("t4_ld_ready", {31'b0, ld_ready}, {31'b0, exp_rdy4[c]});
      if (reg_write && rd >= 5'd8 && rd <= 5'd12) begin
        wr_rds.push_back(int'(rd)); wr_cyc.push_back(c);
      end
      acc = ld_valid && ld_ready;
      adv();
      if (acc) k++;
    end
    chk("t4_drained", wr_rds.size(), 32'd5);
    if (wr_cyc.size() > 0) chk("t4_first_cycle", wr_cyc[0], 32'd7);
    for (int i = 0; i < wr_rds.size(); i++) begin
      chk("t4_order", wr_rds[i], 32'(8 + i));
      if (i > 0) chk("t4_back_to_back", wr_cyc[i] - wr_cyc[i-1], 32'd1);
    end
    idle();

    // Reissue to x9 in the cycle its load writes back.
    issue_valid = 1; issue_rd = 5'd9;
    sample(); adv();
    idle(); ld_valid = 1; ld_rd = 5'd9; ld_data = 32'h99;
    sample(); adv();
    idle();
    sample(); adv();
    issue_valid = 1; issue_rd = 5'd9;
    sample();
    chk("t5_reg_write", {31'b0, reg_write}, 32'd1);
    chk("t5_rd", {27'b0, rd}, 32'd9);
    chk("t5_stall", {31'b0, stall}, 32'd1);
    adv();
    idle();
    sample(); chk("t5_busy9", {31'b0, busy[9]}, 32'd1); adv();

    // Reset with three queued loads and x8/x9 pending.
    for (int i = 0; i < 3; i++) begin
      idle();
      if (i == 0) begin issue_valid = 1; issue_rd = 5'd8; end
      alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h300 + 32'(i);
      ld_valid = 1; ld_rd = 5'(20 + i); ld_data = 32'h2000 + 32'(i);
      sample(); adv();
    end
    idle(); rst = 1;
    sample(); chk("t6_busy_before", busy, 32'h0000_0300); adv();
    rst = 0;
    sample();
    chk("t6_busy_after", busy, 32'd0);
    chk("t6_no_write", {31'b0, reg_write}, 32'd0);
    adv();
    for (int i = 0; i < 5; i++) begin
      sample(); chk("t6_no_write", {31'b0, reg_write}, 32'd0); adv();
    end

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(59) == 0);
      alu_valid = ($urandom_range(2) == 0);
      alu_rd    = 5'($urandom_range(31));
      alu_data  = $urandom;
      ld_valid  = ($urandom_range(1) == 0);
      ld_rd     = 5'($urandom_range(31));
      ld_data   = $urandom;
      r         = 5'($urandom_range(31));
      issue_rd  = r;
      issue_valid = ($urandom_range(2) == 0) && !mbusy[r];
      rs1       = 5'($urandom_range(31));
      rs2       = 5'($urandom_range(31));
      sample(); adv();
    end
    idle(); rst = 0;
    for (int i = 0; i < 8; i++) begin sample(); adv(); end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/writeback_unit.md
# writeback_unit

Write-side driver of the 32×32 register file: merges single-cycle ALU results and variable-latency load returns onto the file's single write port (`rd`, `write_data`, `reg_write`). Holds a per-register pending-load scoreboard so decode stalls instead of reading stale data. Sits between execute/memory and the register file; its registered outputs connect directly to the file's write port.

## Interface
Parameters:
- `LQ_DEPTH`, 4: load-return FIFO entries; power of two, ≥2.
- `XLEN`, 32: data width.

Ports:
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `alu_valid` input 1: ALU result present this cycle; there is no back-pressure.
- `alu_rd` input 5: ALU destination.
- `alu_data` input XLEN: ALU result.
- `ld_valid` input 1: load return offered.
- `ld_ready` output 1: load return accepted when `ld_valid && ld_ready`.
- `ld_rd` input 5: load destination.
- `ld_data` input XLEN: load data.
- `issue_valid` input 1: a load issues this cycle.
- `issue_rd` input 5: destination of the issuing load.
- `rs1`, `rs2` input 5: decode source registers.
- `stall` output 1: decode must hold.
- `busy` output 32: scoreboard bitmap; bit 0 is always 0.
- `rd` output 5: register file write address.
- `write_data` output XLEN: register file write data.
- `reg_write` output 1: register file write enable.

## Operation
- **Load FIFO.**
  - `ld_ready = !rst && count != LQ_DEPTH`.
  - A full FIFO deasserts ready even if a pop occurs in the same cycle; there is no pass-through.
  - An accepted return with `ld_rd == 0` is consumed but not pushed.
- **Arbiter.** Evaluated every cycle, in priority order:
  1. If `alu_valid && alu_rd != 0`, select ALU.
  2. Otherwise, if the FIFO is non-empty, pop the head and select it.
  3. Otherwise, select nothing.
  - `alu_valid` with `alu_rd == 0` counts as no request; the FIFO may drain that cycle.
  - Loads can starve under continuous ALU traffic. This is accepted: pipeline occupancy guarantees gaps.
- **Output register.**
  - On a selection: `rd`, `write_data`, `reg_write=1` are loaded at the next edge, plus an internal `wb_is_load` flag.
  - With no selection: `reg_write=0`; `rd` and `write_data` hold.
- **Scoreboard.**
  - Set: `issue_valid && issue_rd != 0` sets `busy[issue_rd]`.
  - Clear: `reg_write && wb_is_load` clears `busy[rd]` at the same edge the register file writes.
  - Set and clear of the same bit at one edge: set wins.
- **Stall.**
  - `stall = busy[rs1] | busy[rs2] | (issue_valid & busy[issue_rd])`. Combinational.
  - Issuing to an already-busy register without stalling is illegal; the bench asserts on it.
- **Scope.** ALU-to-ALU hazards are resolved by execute forwarding and are outside this block.

## Timing
- **Reset.**
  - Outputs: `reg_write=0`, `rd=0`, `write_data=0`, `busy=0`, `ld_ready=0`, `stall=0`. FIFO is empty.
  - Reset mid-operation discards FIFO contents and in-flight writes. Upstream reissues.
- **ALU latency.** `alu_valid` in cycle T gives `reg_write` high in T+1. The register file is updated at the edge ending T+1.
- **Load latency.** Accepted in T → enters FIFO at end of T → earliest pop in T+1 → `reg_write` in T+2 → busy clears at end of T+2 → decode stall drops in T+3 and reads new data.
- **Throughput.** One register write per cycle, sustained. FIFO pushes and pops may occur in the same cycle.
- **Pointers.** Width log2(LQ_DEPTH), wrap naturally. `count` has width log2(LQ_DEPTH)+1.

## Structure
- **Shared package `riscv_pkg`:**
  - `XLEN=32`
  - `REG_ADDR_W=5`
  - `NUM_REGS=32`
  - `wb_entry_t` {rd, data}
- **Sub-module `wb_fifo`:** a generic synchronous FIFO (push/pop/full/empty/count, sync active-high `rst`). It is reused later by the store buffer.
- **Top-level contents:** arbiter, output register and scoreboard stay in `writeback_unit`.

## Test plan
1. **Reset.** Assert `rst` 2 cycles with `ld_valid=1` → `ld_ready=0`, `reg_write=0`, `busy=0` throughout; `ld_ready=1` the cycle after release.
2. **ALU path.** `alu_valid`, `alu_rd=5`, `alu_data=32'hDEADBEEF` in T → T+1: `reg_write=1`, `rd=5`, `write_data=DEADBEEF`. Then `alu_rd=0` → no write.
3. **Load with scoreboard.**
   - Stimulus: issue x7 in T0; `rs1=7` held; return (`ld_rd=7`, `ld_data=32'h1234`) in T5.
   - Required: `stall=1` from T0+1; write in T7; `busy[7]=0` and `stall=0` in T8.
4. **Collision and starvation.**
   - Stimulus: ALU writes x3 every cycle for 6 cycles while 5 loads (x8–x12) are offered.
   - Required: `ld_ready` drops after 4 accepts; loads drain x8..x12 in order, one per cycle, once ALU idles.
5. **Simultaneous set/clear.** Load to x9 completes (`reg_write`, `wb_is_load`) in the same cycle `issue_rd=9` issues → `busy[9]` stays 1.
6. **Mid-operation reset.** Reset with 3 FIFO entries and `busy=0x0000_0300` → FIFO empty, `busy=0`, no `reg_write` for any discarded entry afterward.
